// File: rtl/matrix_loader_if.sv
// Element stream, matrix output and handshake bundle for matrix_loader.
// slave is the loader side, master is the producer/consumer side.
interface matrix_loader_if #(
    parameter int DIM_MAX = 5,
    parameter int ELEM_W  = 8
);
    localparam int MAT_W = DIM_MAX * DIM_MAX * ELEM_W;

    logic              start;
    logic [2:0]        size;
    logic              in_valid;
    logic [ELEM_W-1:0] in_data;
    logic              in_ready;
    logic [MAT_W-1:0]  mat_a;
    logic [MAT_W-1:0]  mat_b;
    logic [2:0]        mat_size;
    logic              mat_valid;
    logic              mat_ack;
    logic              busy;
    logic              err;

    modport master (
        output start, size, in_valid, in_data, mat_ack,
        input  in_ready, mat_a, mat_b, mat_size, mat_valid, busy, err
    );

    modport slave (
        input  start, size, in_valid, in_data, mat_ack,
        output in_ready, mat_a, mat_b, mat_size, mat_valid, busy, err
    );
endinterface

// File: rtl/matrix_loader.sv
// Loads an NxN matrix A (row-major) then B (stored transposed) from an
// element stream into fixed DIM_MAX x DIM_MAX slot buses, then holds them
// until the consumer acknowledges.
module matrix_loader #(
    parameter int DIM_MAX = 5,
    parameter int ELEM_W  = 8
) (
    input logic            clk,
    input logic            rst,
    matrix_loader_if.slave bus
);
    localparam int SLOTS  = DIM_MAX * DIM_MAX;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int MAT_W  = SLOTS * ELEM_W;

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_t;

    state_t            state_q, state_d;
    logic [2:0]        row_q, col_q, size_q;
    logic              err_q;
    logic [MAT_W-1:0]  a_q, b_q;
    logic              size_ok, loading, accept, last_col, last_row;
    logic [SLOT_W-1:0] slot_a, slot_b;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state, handshake decode and write-slot addressing
    always_comb begin
        size_ok  = (bus.size >= 3'd2) && (bus.size <= 3'(DIM_MAX));
        loading  = (state_q == LOAD_A) || (state_q == LOAD_B);
        accept   = loading && bus.in_valid;
        last_col = (col_q == size_q - 3'd1);
        last_row = (row_q == size_q - 3'd1);
        slot_a   = SLOT_W'(row_q) * SLOT_W'(DIM_MAX) + SLOT_W'(col_q);
        slot_b   = SLOT_W'(col_q) * SLOT_W'(DIM_MAX) + SLOT_W'(row_q);
        state_d  = state_q;
        unique case (state_q)
            IDLE:    if (bus.start && size_ok)            state_d = LOAD_A;
            LOAD_A:  if (accept && last_row && last_col)  state_d = LOAD_B;
            LOAD_B:  if (accept && last_row && last_col)  state_d = HOLD;
            HOLD:    if (bus.mat_ack)                     state_d = IDLE;
            default:                                      state_d = IDLE;
        endcase
    end

    // Matrix storage, size latch, sticky error flag and row/col counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            size_q <= '0;
            err_q  <= 1'b0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (state_q == IDLE && bus.start) begin
            if (size_ok) begin
                a_q    <= '0;
                b_q    <= '0;
                size_q <= bus.size;
                err_q  <= 1'b0;
                row_q  <= '0;
                col_q  <= '0;
            end else begin
                err_q  <= 1'b1;
            end
        end else if (accept) begin
            // Slot k sits at the MSB end: decode the slot against every k
            // so the part-selects stay constant.
            for (int unsigned k = 0; k < SLOTS; k++) begin
                if (state_q == LOAD_A && slot_a == SLOT_W'(k))
                    a_q[MAT_W-1-ELEM_W*k -: ELEM_W] <= bus.in_data;
                if (state_q == LOAD_B && slot_b == SLOT_W'(k))
                    b_q[MAT_W-1-ELEM_W*k -: ELEM_W] <= bus.in_data;
            end
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? 3'd0 : row_q + 3'd1;
            end else begin
                col_q <= col_q + 3'd1;
            end
        end
    end

    assign bus.in_ready  = loading;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mat_valid = (state_q == HOLD);
    assign bus.mat_a     = a_q;
    assign bus.mat_b     = b_q;
    assign bus.mat_size  = size_q;
    assign bus.err       = err_q;
endmodule
